// File: rtl/counter_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_display_ctrl
// Purpose  : Button-driven up/down counter with binary/BCD mode, input
//            synchronisation, debounce and registered seven-segment decode.
// Revision : 1.0 - initial release
// ============================================================================
module counter_display_ctrl #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 2,
  parameter int DEBOUNCE       = 50000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            buttons,
  output logic [WIDTH-1:0]      led,
  output logic [8*DIGITS-1:0]   seven_seg,
  output logic                  mode_bcd
);

  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE - 1);
  localparam logic [2:0]     RELEASED = (BTN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  // Elaboration guards on the parameter set.
  if (WIDTH != 4 * DIGITS) begin : g_width_check
    $error("counter_display_ctrl: WIDTH must equal 4*DIGITS");
  end
  if (DEBOUNCE < 1) begin : g_debounce_check
    $error("counter_display_ctrl: DEBOUNCE must be at least 1");
  end

  logic [2:0]       sync_a;
  logic [2:0]       sync_b;
  logic [2:0]       level;
  logic [2:0]       stable;
  logic [2:0]       stable_d;
  logic [2:0]       press;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             mode;
  logic             mode_next;
  logic [WIDTH-1:0] bcd_inc;
  logic [WIDTH-1:0] bcd_dec;
  logic             carry;
  logic             borrow;
  logic [3:0]       nib;
  logic [8*DIGITS-1:0] seg_next;

  // Two-flop synchroniser; flops reset to the released electrical level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a <= RELEASED;
      sync_b <= RELEASED;
    end else begin
      sync_a <= buttons;
      sync_b <= sync_a;
    end
  end

  // Normalise polarity so that pressed reads as 1.
  assign level = sync_b ^ RELEASED;

  for (genvar b = 0; b < 3; b++) begin : g_debounce
    logic          stable_bit;
    logic [CW-1:0] db_cnt;

    // Accept a new level only after DEBOUNCE consecutive differing cycles.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        stable_bit <= 1'b0;
        db_cnt     <= '0;
      end else if (level[b] != stable_bit) begin
        if (db_cnt == DB_LAST) begin
          stable_bit <= level[b];
          db_cnt     <= '0;
        end else begin
          db_cnt <= db_cnt + CW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end

    assign stable[b] = stable_bit;
  end

  // Registered one-cycle press pulse on each debounced 0->1 edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_d <= 3'b000;
      press    <= 3'b000;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

  // Packed-BCD increment and decrement with per-nibble carry/borrow chains.
  always_comb begin
    carry   = 1'b1;
    borrow  = 1'b1;
    nib     = 4'd0;
    bcd_inc = count;
    bcd_dec = count;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count[4*i +: 4];
      if (carry) begin
        if (nib == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = nib + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (nib == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = nib - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Next count/mode: mode press wins, simultaneous inc+dec cancels.
  always_comb begin
    count_next = count;
    mode_next  = mode;
    if (press[2]) begin
      mode_next  = ~mode;
      count_next = '0;
    end else if (press[0] ^ press[1]) begin
      if (mode) begin
        count_next = press[0] ? bcd_inc : bcd_dec;
      end else begin
        count_next = press[0] ? (count + WIDTH'(1)) : (count - WIDTH'(1));
      end
    end
  end

  // Count and mode state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      mode  <= 1'b0;
    end else begin
      count <= count_next;
      mode  <= mode_next;
    end
  end

  function automatic logic [7:0] hex_font(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    // Digit 0 decimal point lights to indicate BCD mode.
    if (d == 0) begin : g_dp
      assign seg_next[8*d +: 8] = hex_font(count[4*d +: 4]) & {~mode, 7'h7F};
    end else begin : g_nodp
      assign seg_next[8*d +: 8] = hex_font(count[4*d +: 4]);
    end
  end

  // Output registers, one edge behind the count register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led       <= '0;
      mode_bcd  <= 1'b0;
      seven_seg <= {DIGITS{8'hC0}};
    end else begin
      led       <= count;
      mode_bcd  <= mode;
      seven_seg <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_display_ctrl
// Purpose  : Scoreboard bench for counter_display_ctrl (DEBOUNCE=4,
//            active-low buttons, 2 digits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_display_ctrl;

  localparam int DB = 4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  buttons;
  logic [7:0]  led;
  logic [15:0] seven_seg;
  logic        mode_bcd;

  counter_display_ctrl #(
    .WIDTH(8), .DIGITS(2), .DEBOUNCE(DB), .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons),
    .led(led), .seven_seg(seven_seg), .mode_bcd(mode_bcd)
  );

  typedef struct {
    string       tag;
    logic [7:0]  led;
    logic [15:0] seg;
    logic        mode;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          mon_en = 0;
  logic [24:0] prev;
  logic [7:0]  m_cnt  = 8'h00;
  logic        m_mode = 1'b0;

  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_seg(input logic [7:0] c, input logic m);
    return {font[c[7:4]], font[c[3:0]] & (m ? 8'h7F : 8'hFF)};
  endfunction

  function automatic logic [7:0] dec_step(input logic [7:0] v, input int d);
    int x;
    x = int'(v[7:4]) * 10 + int'(v[3:0]);
    x = (x + d + 100) % 100;
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic push_exp(input string tag, input int due);
    exp_t e;
    e.tag  = tag;
    e.led  = m_cnt;
    e.seg  = model_seg(m_cnt, m_mode);
    e.mode = m_mode;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Apply one accepted press pattern to the reference model.
  task automatic model_apply(input logic [2:0] mask);
    if (mask[2]) begin
      m_mode = ~m_mode;
      m_cnt  = 8'h00;
    end else if (mask[0] ^ mask[1]) begin
      if (m_mode) m_cnt = dec_step(m_cnt, mask[0] ? 1 : -1);
      else        m_cnt = mask[0] ? m_cnt + 8'd1 : m_cnt - 8'd1;
    end
  endtask

  task automatic drain(input string tag);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  // Hold the pressed mask for 'hold' cycles, release, and let things settle.
  task automatic tap(input logic [2:0] mask, input int hold, input bit counts);
    logic [7:0] oc;
    logic       om;
    @(negedge clk);
    buttons = ~mask;
    if (counts) begin
      oc = m_cnt;
      om = m_mode;
      model_apply(mask);
      if (m_cnt !== oc || m_mode !== om) push_exp("press", cyc + DB + 5);
    end
    repeat (hold) @(negedge clk);
    buttons = 3'b111;
    repeat (16) @(negedge clk);
    drain("drain");
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    m_cnt   = 8'h00;
    m_mode  = 1'b0;
    push_exp("reset", -1);
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Output monitor: every output change must match the next scoreboard entry.
  always @(negedge clk) begin
    logic [24:0] cur;
    exp_t        e;
    cur = {led, seven_seg, mode_bcd};
    if (mon_en && cur !== prev) begin
      if (sb.size() == 0) begin
        check("spurious_change", 32'(cur), 32'(prev));
      end else begin
        e = sb.pop_front();
        check({e.tag, "_led"},  32'(led),       32'(e.led));
        check({e.tag, "_seg"},  32'(seven_seg), 32'(e.seg));
        check({e.tag, "_mode"}, 32'(mode_bcd),  32'(e.mode));
        if (e.due >= 0) check({e.tag, "_latency"}, cyc, e.due);
      end
    end
    prev = cur;
  end

  initial begin
    buttons = 3'b111;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_led", 32'(led), 32'h00);
    check("rst_seg", 32'(seven_seg), 32'hC0C0);
    check("rst_mode", 32'(mode_bcd), 32'h0);
    mon_en = 1;
    repeat (20) @(negedge clk);
    check("idle_led", 32'(led), 32'h00);
    check("idle_seg", 32'(seven_seg), 32'hC0C0);

    // Binary increment x17
    for (int i = 0; i < 17; i++) tap(3'b001, 10, 1);
    check("inc17_led", 32'(led), 32'h11);
    check("inc17_seg", 32'(seven_seg), 32'hF9F9);

    // Binary wrap both ways
    do_reset(3);
    tap(3'b010, 10, 1);
    check("wrap_dec_led", 32'(led), 32'hFF);
    check("wrap_dec_seg", 32'(seven_seg), 32'h8E8E);
    tap(3'b001, 10, 1);
    check("wrap_inc_led", 32'(led), 32'h00);

    // BCD mode
    tap(3'b100, 10, 1);
    check("bcd_seg", 32'(seven_seg), 32'hC040);
    check("bcd_mode", 32'(mode_bcd), 32'h1);
    for (int i = 0; i < 10; i++) tap(3'b001, 10, 1);
    check("bcd10_led", 32'(led), 32'h10);
    check("bcd10_seg", 32'(seven_seg), 32'hF940);
    tap(3'b100, 10, 1);
    tap(3'b100, 10, 1);
    tap(3'b010, 10, 1);
    check("bcd99_led", 32'(led), 32'h99);
    check("bcd99_seg", 32'(seven_seg), 32'h9010);

    // Glitch and simultaneous presses
    tap(3'b001, 3, 0);
    check("glitch_led", 32'(led), 32'h99);
    tap(3'b011, 10, 1);
    check("incdec_led", 32'(led), 32'h99);
    tap(3'b100, 10, 1);
    for (int i = 0; i < 5; i++) tap(3'b001, 10, 1);
    check("five_led", 32'(led), 32'h05);
    tap(3'b101, 10, 1);
    check("modeinc_led", 32'(led), 32'h00);
    check("modeinc_mode", 32'(mode_bcd), 32'h1);

    // Reset while a dec press is debouncing; held dec counts once afterwards
    @(negedge clk);
    buttons = 3'b101;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    m_cnt   = 8'h00;
    m_mode  = 1'b0;
    push_exp("midreset", -1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_cnt   = 8'hFF;
    push_exp("held_dec", cyc + DB + 5);
    repeat (12) @(negedge clk);
    buttons = 3'b111;
    repeat (16) @(negedge clk);
    drain("drain_held");
    check("held_led", 32'(led), 32'hFF);
    check("held_mode", 32'(mode_bcd), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/counter_display_ctrl.md
# counter_display_ctrl

Parametrised button-driven counter for the board-level count demo. It replaces the fixed software-polled binary counter path with a self-contained block between the raw push-button inputs and the LED and seven-segment pins. The block adds input synchronisation, debounce, up/down counting, a binary/BCD mode, and registered seven-segment decoding for any digit count.

## Interface

Parameters:
- `WIDTH`, default 8: counter and LED width. Elaboration must fail unless WIDTH == 4*DIGITS.
- `DIGITS`, default 2: number of seven-segment digits, 8 bits each.
- `DEBOUNCE`, default 50000: consecutive stable cycles required to accept a button change. Minimum 1.
- `BTN_ACTIVE_LOW`, default 1: when 1, buttons read 0 when pressed.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  synchronous reset, active low.
- `buttons`  in  3  raw, asynchronous buttons. [0] = increment, [1] = decrement, [2] = mode toggle.
- `led`  out  WIDTH  current count register, registered.
- `seven_seg`  out  8*DIGITS  active-low segments. Digit i occupies [8i+7:8i], ordered {dp,g,f,e,d,c,b,a}. Digit 0 is the least significant. Registered.
- `mode_bcd`  out  1  1 = BCD mode, 0 = binary mode, registered.

## Operation

Input path:
- Each button passes through a 2-flop synchroniser, then polarity normalisation (pressed = 1).
- Debounce, per button:
  - Keep a `stable` bit and a counter.
  - When the synchronised value differs from `stable`, the counter increments.
  - When it equals `stable`, the counter clears.
  - When the counter reaches DEBOUNCE, `stable` takes the new value and the counter clears.
- Press pulse: one-cycle pulse on each `stable` 0→1 transition. Releases generate nothing.

Counter update, evaluated on press pulses in the same cycle:
- Mode pulse present: toggle the mode, clear the count to 0, and ignore inc/dec in that cycle.
- Inc and dec both present: no change.
- Inc only, binary mode: count+1 modulo 2^WIDTH.
- Dec only, binary mode: count−1 modulo 2^WIDTH.
- BCD mode: the count is held as DIGITS packed BCD nibbles, with the value modulo 10^DIGITS.
  - Inc carries per nibble: 9→0 with carry. All 9s wraps to all 0s.
  - Dec borrows: 0→9 with borrow. All 0s wraps to all 9s.
  - Nibbles never hold A–F in BCD mode.

Outputs:
- `led` = the count register.
- Digit i shows count[4i+3:4i] in the hex font. Segment bytes by value:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Digit 0 dp bit is low (lit) when `mode_bcd` = 1. All other dp bits stay high.

Reset (reset_n low at a rising edge):
- Count = 0 and mode = binary.
- All synchroniser flops, `stable` bits and debounce counters clear to released / 0.
- Outputs: `led` = 0, `mode_bcd` = 0, `seven_seg` = C0 repeated DIGITS times (16'hC0C0 at default).
- Reset asserted mid-debounce or mid-press discards the pending event. A button held through reset release must be debounced afresh and then counts as one press.

## Timing

- The synchroniser adds 2 cycles.
- `stable` updates DEBOUNCE cycles after the synchronised value changes.
- The count register updates on the edge after the press pulse. `led`, `seven_seg` and `mode_bcd` update one edge later.
- Fixed latency: a button level applied before edge 0 and held appears on the outputs after edge DEBOUNCE+4.
- Throughput: at most one count change per accepted press. Presses are separated by at least 2*DEBOUNCE cycles by construction.
- Glitches shorter than DEBOUNCE synchronised cycles have no effect.
- No combinational path from inputs to outputs.

## Test plan

Use DEBOUNCE=4, defaults otherwise, and active-low buttons.

- Reset: hold reset_n=0 for 3 cycles, then release -> `led`=00, `seven_seg`=C0C0, `mode_bcd`=0. Outputs hold with buttons idle.
- Binary increment: 17 clean inc presses -> `led`=11, `seven_seg`=F9F9. Output change observed exactly DEBOUNCE+4 = 8 cycles after the first press.
- Binary wrap: from reset, one dec press -> `led`=FF, `seven_seg`=8E8E. Then one inc press -> `led`=00.
- BCD mode:
  - Mode press -> `mode_bcd`=1, `led`=00, `seven_seg`=C040.
  - 10 inc presses -> `led`=10, `seven_seg`=F940.
  - From 00, one dec press -> `led`=99, `seven_seg`=9010.
- Glitch and simultaneity:
  - Inc held for 3 cycles, then released -> no change.
  - Inc and dec pressed on the same cycle -> no change.
  - Mode and inc pressed on the same cycle at count 05 (binary) -> BCD mode, `led`=00.
- Reset mid-operation: assert reset_n=0 while a dec press is 2 cycles into debounce -> outputs return to reset values. Dec still held after release -> exactly one decrement, to FF, DEBOUNCE+4 cycles later.
